// File: rtl/run_sequencer.sv
// Run controller: debounced start, job config latch, CPU reset hold, completion watch.
// Define WATCHDOG_EN to add the RUN-time watchdog and the ERROR/timeout status.
module run_sequencer #(
  parameter logic [31:0] DONE_ADDR       = 32'h0000_FFFC,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          RESET_HOLD      = 4,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'h00FF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_button,
  input  logic        image_select,
  input  logic        interpolation_type,
  input  logic [3:0]  quadrant,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        cfg_image_select,
  output logic        cfg_interpolation_type,
  output logic [3:0]  cfg_quadrant,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] cycle_count
);

`ifdef WATCHDOG_EN
  localparam bit WATCHDOG = 1'b1;
`else
  localparam bit WATCHDOG = 1'b0;
`endif

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DEBOUNCE, S_HOLD_RST, S_RUN, S_DONE, S_ERROR
  } state_t;

  state_t          state_reg;
  state_t          origin_reg;
  logic            sync_reg;
  logic            btn_s;
  logic [DW-1:0]   deb_cnt_reg;
  logic [HW-1:0]   hold_cnt_reg;
  logic            released_reg;
  logic            completion;

  assign completion = mem_write && (mem_addr == DONE_ADDR) && (mem_wdata != 32'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg              <= S_IDLE;
      origin_reg             <= S_IDLE;
      sync_reg               <= 1'b0;
      btn_s                  <= 1'b0;
      deb_cnt_reg            <= '0;
      hold_cnt_reg           <= '0;
      released_reg           <= 1'b0;
      cpu_rst                <= 1'b1;
      cfg_image_select       <= 1'b0;
      cfg_interpolation_type <= 1'b0;
      cfg_quadrant           <= 4'd0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      timeout                <= 1'b0;
      cycle_count            <= 32'd0;
    end else begin
      sync_reg <= start_button;
      btn_s    <= sync_reg;
      case (state_reg)
        S_IDLE: begin
          if (btn_s) begin
            origin_reg  <= S_IDLE;
            deb_cnt_reg <= '0;
            state_reg   <= S_DEBOUNCE;
          end
        end
        S_DONE, S_ERROR: begin
          // A button still held from the previous job must be released first.
          if (!btn_s) begin
            released_reg <= 1'b1;
          end else if (released_reg) begin
            origin_reg  <= state_reg;
            deb_cnt_reg <= '0;
            state_reg   <= S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (!btn_s) begin
            state_reg <= origin_reg;
          end else if (deb_cnt_reg == DEB_LAST) begin
            cfg_image_select       <= image_select;
            cfg_interpolation_type <= interpolation_type;
            cfg_quadrant           <= quadrant;
            cycle_count            <= 32'd0;
            done                   <= 1'b0;
            timeout                <= 1'b0;
            busy                   <= 1'b1;
            hold_cnt_reg           <= '0;
            state_reg              <= S_HOLD_RST;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
          end
        end
        S_HOLD_RST: begin
          if (hold_cnt_reg == HOLD_LAST) begin
            cpu_rst   <= 1'b0;
            state_reg <= S_RUN;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        S_RUN: begin
          if (cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (completion) begin
            cpu_rst      <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b1;
            released_reg <= 1'b0;
            state_reg    <= S_DONE;
          end else if (WATCHDOG && (cycle_count == TIMEOUT_CYCLES - 32'd1)) begin
            cpu_rst      <= 1'b1;
            busy         <= 1'b0;
            timeout      <= 1'b1;
            released_reg <= 1'b0;
            state_reg    <= S_ERROR;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized and directed bench for run_sequencer against a job-level reference model.
module tb_run_sequencer;

  localparam logic [31:0] DADDR = 32'h0000_FFFC;
  localparam int          DEB   = 16;
  localparam int          HOLD  = 4;
  localparam longint      TO    = 50;
`ifdef WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_button = 1'b0;
  logic        image_select = 1'b0;
  logic        interpolation_type = 1'b0;
  logic [3:0]  quadrant = 4'd0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic        cpu_rst, cfg_image_select, cfg_interpolation_type, busy, done, timeout;
  logic [3:0]  cfg_quadrant;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  run_sequencer #(
    .DONE_ADDR(DADDR), .DEBOUNCE_CYCLES(DEB), .RESET_HOLD(HOLD), .TIMEOUT_CYCLES(32'd50)
  ) dut (
    .clk(clk), .rst(rst), .start_button(start_button), .image_select(image_select),
    .interpolation_type(interpolation_type), .quadrant(quadrant), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
    .cfg_image_select(cfg_image_select), .cfg_interpolation_type(cfg_interpolation_type),
    .cfg_quadrant(cfg_quadrant), .busy(busy), .done(done), .timeout(timeout),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: job phase, press length, hold countdown and run-cycle tally.
  localparam int P_IDLE = 0, P_DEB = 1, P_HOLD = 2, P_RUN = 3, P_DONE = 4, P_ERR = 5;
  int     ph = P_IDLE, origin = P_IDLE, press_len = 0, hold_left = 0;
  bit     armed = 0, s1 = 0, s2 = 0, model_valid = 0;
  bit     m_cpu_rst = 1, m_img = 0, m_interp = 0, m_busy = 0, m_done = 0, m_to = 0;
  bit [3:0] m_q = 0;
  longint m_count = 0;

  always @(posedge clk) begin
    bit b;
    b = s2;
    if (rst) begin
      ph = P_IDLE; origin = P_IDLE; press_len = 0; hold_left = 0; armed = 0;
      s1 = 0; s2 = 0; m_cpu_rst = 1; m_img = 0; m_interp = 0; m_q = 0;
      m_busy = 0; m_done = 0; m_to = 0; m_count = 0; model_valid = 1;
    end else begin
      s2 = s1;
      s1 = start_button;
      if (ph == P_IDLE || ph == P_DONE || ph == P_ERR) begin
        if (b && (ph == P_IDLE || armed)) begin
          origin = ph; ph = P_DEB; press_len = 0;
        end else if (!b) begin
          armed = 1;
        end
      end else if (ph == P_DEB) begin
        if (!b) ph = origin;
        else begin
          press_len++;
          if (press_len == DEB) begin
            m_img = image_select; m_interp = interpolation_type; m_q = quadrant;
            m_count = 0; m_done = 0; m_to = 0; m_busy = 1;
            hold_left = HOLD; ph = P_HOLD;
          end
        end
      end else if (ph == P_HOLD) begin
        hold_left--;
        if (hold_left == 0) begin ph = P_RUN; m_cpu_rst = 0; end
      end else if (ph == P_RUN) begin
        if (m_count < 64'h0000_0000_FFFF_FFFF) m_count++;
        if (mem_write && mem_addr == DADDR && mem_wdata != 0) begin
          ph = P_DONE; m_cpu_rst = 1; m_busy = 0; m_done = 1; armed = 0;
        end else if (WD && m_count == TO) begin
          ph = P_ERR; m_cpu_rst = 1; m_busy = 0; m_to = 1; armed = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("cpu_rst", {31'd0, cpu_rst}, {31'd0, m_cpu_rst});
      chk("cfg_image_select", {31'd0, cfg_image_select}, {31'd0, m_img});
      chk("cfg_interpolation_type", {31'd0, cfg_interpolation_type}, {31'd0, m_interp});
      chk("cfg_quadrant", {28'd0, cfg_quadrant}, {28'd0, m_q});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("timeout", {31'd0, timeout}, {31'd0, m_to});
      chk("cycle_count", cycle_count, m_count[31:0]);
    end
  end

  task automatic press(input int n);
    start_button = 1'b1;
    repeat (n) @(negedge clk);
    start_button = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1; mem_addr = a; mem_wdata = d;
    @(negedge clk);
    mem_write = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
  endtask

  initial begin
    int seg_left;
    bit level;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("lit_reset_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("lit_reset_busy", {31'd0, busy}, 32'd0);
    chk("lit_reset_count", cycle_count, 32'd0);

    // Short press: too brief to register.
    press(10);
    repeat (10) @(negedge clk);
    chk("lit_short_cfg_q", {28'd0, cfg_quadrant}, 32'd0);
    chk("lit_short_busy", {31'd0, busy}, 32'd0);
    chk("lit_short_cpu_rst", {31'd0, cpu_rst}, 32'd1);

    // Job 1: latch switches, then change them mid-run.
    quadrant = 4'b0100; interpolation_type = 1'b1; image_select = 1'b1;
    press(20);
    repeat (10) @(negedge clk);
    chk("lit_j1_cfg_q", {28'd0, cfg_quadrant}, 32'h4);
    chk("lit_j1_cfg_interp", {31'd0, cfg_interpolation_type}, 32'd1);
    chk("lit_j1_cfg_img", {31'd0, cfg_image_select}, 32'd1);
    chk("lit_j1_busy", {31'd0, busy}, 32'd1);
    chk("lit_j1_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    quadrant = 4'b1011; interpolation_type = 1'b0; image_select = 1'b0;
    store(DADDR, 32'd0);
    repeat (99) @(negedge clk);
    chk("lit_j1_pre_count", cycle_count, WD ? 32'd50 : 32'd107);
    chk("lit_j1_pre_done", {31'd0, done}, 32'd0);
    store(DADDR, 32'd1);
    chk("lit_j1_done", {31'd0, done}, WD ? 32'd0 : 32'd1);
    chk("lit_j1_timeout", {31'd0, timeout}, WD ? 32'd1 : 32'd0);
    chk("lit_j1_count", cycle_count, WD ? 32'd50 : 32'd108);
    chk("lit_j1_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("lit_j1_cfg_q_kept", {28'd0, cfg_quadrant}, 32'h4);

    // Job 2: button held through completion must not retrigger.
    repeat (5) @(negedge clk);
    start_button = 1'b1;
    repeat (40) @(negedge clk);
    store(DADDR, 32'h1234);
    chk("lit_j2_done", {31'd0, done}, 32'd1);
    chk("lit_j2_count", cycle_count, 32'd18);
    repeat (30) @(negedge clk);
    chk("lit_held_done", {31'd0, done}, 32'd1);
    chk("lit_held_busy", {31'd0, busy}, 32'd0);
    chk("lit_held_count", cycle_count, 32'd18);
    start_button = 1'b0;
    @(negedge clk);
    start_button = 1'b1;
    repeat (25) @(negedge clk);
    start_button = 1'b0;
    chk("lit_rearm_done", {31'd0, done}, 32'd0);
    chk("lit_rearm_busy", {31'd0, busy}, 32'd1);
    chk("lit_rearm_count", cycle_count, 32'd2);
    store(DADDR, 32'd7);
    chk("lit_rearm_count_end", cycle_count, 32'd3);

    // Job 3: completion on the 50th run cycle.
    repeat (5) @(negedge clk);
    press(20);
    repeat (52) @(negedge clk);
    chk("lit_j3_pre_count", cycle_count, 32'd49);
    store(DADDR, 32'hFFFF_FFFF);
    chk("lit_j3_done", {31'd0, done}, 32'd1);
    chk("lit_j3_timeout", {31'd0, timeout}, 32'd0);
    chk("lit_j3_count", cycle_count, 32'd50);

    // Reset in the middle of a run.
    repeat (5) @(negedge clk);
    press(20);
    repeat (10) @(negedge clk);
    chk("lit_j4_count", cycle_count, 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("lit_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("lit_rst_busy", {31'd0, busy}, 32'd0);
    chk("lit_rst_cfg_q", {28'd0, cfg_quadrant}, 32'd0);
    chk("lit_rst_count", cycle_count, 32'd0);

    // Randomized traffic, checked by the per-cycle compare.
    seg_left = 0;
    level = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (seg_left == 0) begin
        level = ~level;
        seg_left = $urandom_range(1, 40);
      end
      seg_left--;
      start_button = level;
      image_select = 1'($urandom_range(0, 1));
      interpolation_type = 1'($urandom_range(0, 1));
      quadrant = 4'($urandom_range(0, 15));
      mem_write = ($urandom_range(0, 3) == 0);
      mem_addr = ($urandom_range(0, 29) == 0) ? DADDR : $urandom;
      mem_wdata = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      rst = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
